// File: rtl/fifo_pkg.sv
// Shared definitions for the parity-checking FIFO.
//   PARITY_EVEN / PARITY_ODD : values for the PARITY parameter
//   PBIT_LSB / PBIT_MSB      : values for the P_BIT parameter
//   DROP_CNT_W               : width of the dropped-push counter
//   ptr_width()              : pointer width for a given depth (never below 1)
package fifo_pkg;

  localparam bit PARITY_EVEN = 1'b1;
  localparam bit PARITY_ODD  = 1'b0;

  localparam bit PBIT_LSB = 1'b1;
  localparam bit PBIT_MSB = 1'b0;

  localparam int DROP_CNT_W = 16;

  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_parity_buffer_parity_check.sv
// Combinational parity rule applied to a whole word.
//   data : word under test (parity bit included)
//   good : 1 when the word satisfies the configured rule
// PARITY = 1 selects even parity (XOR of all bits is 0),
// PARITY = 0 selects odd parity (XOR of all bits is 1).
module parity_check #(
  parameter int DATA_WIDTH = 17,
  parameter bit PARITY     = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  good
);

  assign good = PARITY ^ (^data);

endmodule

// File: rtl/fifo_parity_buffer.sv
// Synchronous FIFO that drops words failing a parity check.
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid_in    : upstream word present on data_in
//   data_in     : incoming word
//   grant_out   : FIFO can accept a word (not full)
//   valid_out   : data_out holds the oldest stored word
//   data_out    : head-of-FIFO word
//   grant_in    : downstream takes data_out this cycle
//   parity_err  : one-cycle pulse after a dropped push
//   drop_cnt    : saturating count of dropped pushes
//
// Handshake: a transfer happens on a rising edge where the producer's valid
// and the receiver's grant are both high. grant_out depends only on the
// stored count, so a bad-parity word is refused while full just like a good
// one, and a pop in the same cycle never opens a full FIFO.
module fifo_parity_buffer
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 17,
  parameter bit PARITY     = PARITY_EVEN,
  parameter bit P_BIT      = PBIT_LSB
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  grant_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  grant_in,
  output logic                  parity_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // P_BIT only documents where the parity bit lives; the check covers the
  // whole word. A depth below 2 is unsupported, so such a build never grants.
  localparam bit CFG_OK = (FIFO_DEPTH >= 2) &&
                          ((P_BIT == PBIT_LSB) || (P_BIT == PBIT_MSB));

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  parity_err_q, parity_err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic good;
  logic push, pop, push_good, push_bad;

  parity_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARITY     (PARITY)
  ) u_parity_check (
    .data (data_in),
    .good (good)
  );

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign grant_out  = CFG_OK && (count_q != CNT_W'(FIFO_DEPTH));
  assign valid_out  = (count_q != '0);
  assign data_out   = mem_q[rd_ptr_q];
  assign parity_err = parity_err_q;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    push      = valid_in && grant_out;
    pop       = valid_out && grant_in;
    push_good = push && good;
    push_bad  = push && !good;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    parity_err_d = push_bad;
    drop_cnt_d   = drop_cnt_q;

    if (push_good) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    unique case ({push_good, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push_bad && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_q <= 1'b0;
      drop_cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      parity_err_q <= parity_err_d;
      drop_cnt_q   <= drop_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo_parity_buffer.sv
// Self-checking bench for fifo_parity_buffer (default parameters: depth 4,
// 17-bit words, even parity). Stimulus pushes expected words into exp_q;
// a negedge monitor pops and compares whenever the DUT completes a pop.
module tb_fifo_parity_buffer;

  localparam int W = 17;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          grant_out;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic          grant_in;
  logic          parity_err;
  logic [15:0]   drop_cnt;

  logic [W-1:0]  exp_q[$];
  int            n_tests;
  int            n_fail;

  fifo_parity_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .grant_out  (grant_out),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .grant_in   (grant_in),
    .parity_err (parity_err),
    .drop_cnt   (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one word; good is the hand-computed parity verdict for w.
  task automatic drive_push(input logic [W-1:0] w, input bit good);
    int budget;
    budget = 20;
    while (!grant_out && budget > 0) begin
      step();
      budget--;
    end
    if (!grant_out) begin
      check("push_grant_timeout", 32'(grant_out), 32'd1);
    end else begin
      valid_in = 1'b1;
      data_in  = w;
      if (good) exp_q.push_back(w);
      step();
      valid_in = 1'b0;
      data_in  = '0;
      check("parity_err_after_push", 32'(parity_err), 32'(!good));
    end
  endtask

  // Pop until empty, bounded.
  task automatic drain();
    int budget;
    budget = 20;
    grant_in = 1'b1;
    while (valid_out && budget > 0) begin
      step();
      budget--;
    end
    grant_in = 1'b0;
    check("drain_empty", 32'(valid_out), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && valid_out && grant_in) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no pop", data_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", data_out, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Good-parity words for the streaming test (even number of ones each).
  logic [W-1:0] stream_words [10];

  initial begin
    stream_words = '{17'h00014, 17'h00017, 17'h00018, 17'h0001B, 17'h0001D,
                     17'h0001E, 17'h00021, 17'h00022, 17'h00024, 17'h00027};
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    grant_in = 1'b0;

    // Reset state
    #2;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_grant_out", 32'(grant_out), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single good push then pop
    drive_push(17'h00003, 1'b1);
    check("t1_valid_out", 32'(valid_out), 32'd1);
    check("t1_data_out", 32'(data_out), 32'h3);
    check("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    grant_in = 1'b1;
    step();
    grant_in = 1'b0;
    check("t1_empty", 32'(valid_out), 32'd0);

    // Bad-parity push is dropped
    drive_push(17'h00001, 1'b0);
    check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t2_valid_out", 32'(valid_out), 32'd0);
    step();
    check("t2_err_one_cycle", 32'(parity_err), 32'd0);

    // Fill to full, refuse a fifth push, drain in order
    drive_push(17'h00003, 1'b1);
    drive_push(17'h00005, 1'b1);
    drive_push(17'h00006, 1'b1);
    check("t3_grant_before_full", 32'(grant_out), 32'd1);
    drive_push(17'h00009, 1'b1);
    check("t3_grant_full", 32'(grant_out), 32'd0);
    valid_in = 1'b1;
    data_in  = 17'h00011;
    step();
    step();
    check("t3_still_full", 32'(grant_out), 32'd0);
    check("t3_head_stable", 32'(data_out), 32'h3);
    valid_in = 1'b0;
    data_in  = '0;
    grant_in = 1'b1;
    step();
    check("t3_grant_after_pop", 32'(grant_out), 32'd1);
    step();
    step();
    step();
    grant_in = 1'b0;
    check("t3_empty", 32'(valid_out), 32'd0);

    // Steady state at count 2 with push and pop together
    drive_push(17'h00011, 1'b1);
    drive_push(17'h00012, 1'b1);
    grant_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1;
      data_in  = stream_words[i];
      exp_q.push_back(stream_words[i]);
      step();
      check("t4_grant_steady", 32'(grant_out), 32'd1);
      check("t4_valid_steady", 32'(valid_out), 32'd1);
    end
    valid_in = 1'b0;
    grant_in = 1'b0;
    data_in  = '0;
    check("t4_queue_depth", 32'(exp_q.size()), 32'd2);
    drain();

    // Interleaved bad pushes, including back-to-back drops
    drive_push(17'h00003, 1'b1);
    drive_push(17'h00007, 1'b0);
    drive_push(17'h00005, 1'b1);
    valid_in = 1'b1;
    data_in  = 17'h00007;
    step();
    check("t5_b2b_err_1", 32'(parity_err), 32'd1);
    step();
    check("t5_b2b_err_2", 32'(parity_err), 32'd1);
    valid_in = 1'b0;
    data_in  = '0;
    drive_push(17'h00006, 1'b1);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd4);
    drain();

    // Invalid data is ignored even with bad parity
    data_in = 17'h00007;
    step();
    step();
    data_in = '0;
    check("t5_idle_no_err", 32'(parity_err), 32'd0);
    check("t5_idle_drop_cnt", 32'(drop_cnt), 32'd4);

    // Reset mid-operation
    drive_push(17'h00003, 1'b1);
    drive_push(17'h00005, 1'b1);
    drive_push(17'h00006, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_valid_in_reset", 32'(valid_out), 32'd0);
    check("t6_grant_in_reset", 32'(grant_out), 32'd1);
    check("t6_data_in_reset", 32'(data_out), 32'd0);
    check("t6_drop_in_reset", 32'(drop_cnt), 32'd0);
    grant_in = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("t6_no_stale", 32'(valid_out), 32'd0);
    grant_in = 1'b0;
    step();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_parity_buffer.md
# fifo_parity_buffer

Synchronous FIFO that sits between the stimulus driver and the consumer on `fifo_if`. It accepts words with a valid/grant handshake and checks each incoming word against a configurable parity rule. Words with correct parity are stored and presented in order at the output. Words with wrong parity are accepted and then silently discarded. This is the block the FIFO checker scoreboards: only correct-parity pushes may ever appear at `data_out`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: number of storage entries; must be ≥2 and need not be a power of two.
- `DATA_WIDTH`, default 17: word width in bits, parity bit included.
- `PARITY`, default 1'b1: parity rule. 1'b1 = EVEN (XOR of all bits is 0); 1'b0 = ODD (XOR of all bits is 1).
- `P_BIT`, default 1'b1: parity bit position (1 = LSB, 0 = MSB). Informational only; the check covers the whole word and is independent of position.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  upstream has a word on `data_in`.
- `data_in`  in  DATA_WIDTH  input word.
- `grant_out`  out  1  FIFO can accept a word this cycle.
- `valid_out`  out  1  `data_out` holds the oldest stored word.
- `data_out`  out  DATA_WIDTH  head-of-FIFO word.
- `grant_in`  in  1  downstream takes `data_out` this cycle.
- `parity_err`  out  1  one-cycle pulse: the previous push was dropped.
- `drop_cnt`  out  16  count of dropped pushes; saturates at 16'hFFFF.

## Operation
- Push event: `valid_in && grant_out` at a rising edge. Pop event: `valid_out && grant_in` at a rising edge.
- `good = PARITY ^ (^data_in)`.
- Push with `good`: write `data_in` to `mem[wr_ptr]`, advance `wr_ptr`, increment `count`.
- Push with `!good`: no write and no pointer change. `parity_err` is set for the next cycle and `drop_cnt` increments.
- Pop: advance `rd_ptr` and decrement `count`.
- Good push and pop in the same cycle: both pointers advance and `count` is unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` wide (minimum 1 bit) and wrap explicitly from `FIFO_DEPTH-1` to 0.
- `count` is `$clog2(FIFO_DEPTH+1)` wide.
- `grant_out = (count != FIFO_DEPTH)`, combinational from `count` only.
  - A pop in the same cycle does not open a full FIFO.
  - A bad-parity word is not granted while the FIFO is full.
- `valid_out = (count != 0)`.
- `data_out = mem[rd_ptr]`; it is held stable while `valid_out` is high and no pop occurs.
- Pushes on an empty FIFO are not bypassed: the word appears at `data_out` the cycle after it is written.
- No state machine. State consists of `wr_ptr`, `rd_ptr`, `count`, `mem`, `parity_err` and `drop_cnt`.

## Timing
- Reset (asynchronous assert, synchronous release) clears pointers, `count`, `mem`, `parity_err` and `drop_cnt`.
- Output values during and immediately after reset: `valid_out`=0, `grant_out`=1, `data_out`=0, `parity_err`=0, `drop_cnt`=0.
- Reset mid-operation discards all stored words immediately. No pop is reported after reset asserts.
- Latency from a good push to `valid_out`/`data_out` is 1 cycle.
- Latency from a pop to the next head word is 1 cycle.
- `parity_err` rises 1 cycle after a dropped push and stays high for exactly 1 cycle per drop. Back-to-back drops keep it high on consecutive cycles.
- `grant_out` drops in the cycle after the push that fills the FIFO. It rises in the cycle after a pop from full.
- When `valid_in` is low, `data_in` is ignored, including its parity.

## Structure
- Shared package `fifo_pkg` holds:
  - `localparam bit PARITY_EVEN = 1'b1`, `PARITY_ODD = 1'b0`
  - `localparam bit PBIT_LSB = 1'b1`, `PBIT_MSB = 1'b0`
  - `DROP_CNT_W = 16`
- Sub-module `parity_check` (combinational; parameters `DATA_WIDTH`, `PARITY`; input `data`; output `good`) is instantiated on `data_in`. The testbench reuses the same rule.
- Storage is a flat register array; no RAM macro.

## Test plan
Default parameters (depth 4, 17 bits, even parity) for all scenarios.
- Push 17'h00003, then pop → `valid_out`=1 one cycle after the push, `data_out`=17'h00003, `drop_cnt`=0.
- Push 17'h00001 (odd parity) → `parity_err` pulses for 1 cycle, `drop_cnt`=1, `valid_out` stays 0.
- Push 17'h00003, 17'h00005, 17'h00006, 17'h00009 with `grant_in`=0 → `grant_out`=0 after the 4th push. A 5th push with `valid_in`=1 is not accepted. Pop all four → same order returned and `grant_out`=1 again.
- With `count`=2, hold push and pop together for 10 cycles using words 17'h00011, 17'h00012, … (each good-parity) → `count` stays 2, pointers wrap, and pop order equals push order.
- Interleave bad-parity pushes 17'h00007 among good pushes → only good words are popped, in order, and `drop_cnt` equals the number of bad pushes.
- Fill 3 words, assert `rst_n`=0 mid-cycle → `valid_out`=0 and `grant_out`=1 immediately, and no stale word is popped after reset releases.
